// File: rtl/color_percent_calc.sv
// Scales one raw photodiode count against the clear-channel count:
// color = floor(color_raw*SCALE/clear), one restoring-division bit per clock.
module color_percent_calc #(
    parameter int WIDTH = 16,
    parameter int SCALE = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             calc_EN,
    input  logic             calc_reset,
    input  logic [WIDTH-1:0] color_raw,
    input  logic [WIDTH-1:0] clear,
    output logic [7:0]       color,
    output logic             calc_done,
    output logic             div_zero,
    output logic             saturated
);

    localparam int NUM_W = WIDTH + 8;
    localparam int CNT_W = $clog2(NUM_W);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t           state, state_next;
    logic [NUM_W-1:0] dividend;
    logic [NUM_W-1:0] quotient;
    logic [WIDTH:0]   remainder;
    logic [WIDTH-1:0] divisor;
    logic [CNT_W-1:0] bit_cnt;

    logic [NUM_W-1:0] product;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [NUM_W-1:0] quot_next;

    assign product = NUM_W'(color_raw) * NUM_W'(SCALE);

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    always_comb begin
        rem_shift = (remainder << 1) | (WIDTH+1)'(dividend[NUM_W-1]);
        rem_next  = rem_shift;
        q_bit     = 1'b0;
        if (rem_shift >= {1'b0, divisor}) begin
            rem_next = rem_shift - {1'b0, divisor};
            q_bit    = 1'b1;
        end
        quot_next = (quotient << 1) | NUM_W'(q_bit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // calc_reset outranks everything, including a start request.
    always_comb begin
        state_next = state;
        if (calc_reset) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (calc_EN) state_next = (clear == '0) ? DONE : DIV;
                DIV:     if (bit_cnt == '0) state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend  <= '0;
            quotient  <= '0;
            remainder <= '0;
            divisor   <= '0;
            bit_cnt   <= '0;
            color     <= '0;
            calc_done <= 1'b0;
            div_zero  <= 1'b0;
            saturated <= 1'b0;
        end else if (calc_reset) begin
            calc_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (calc_EN) begin
                        divisor   <= clear;
                        dividend  <= product;
                        remainder <= '0;
                        quotient  <= '0;
                        bit_cnt   <= CNT_W'(NUM_W - 1);
                        saturated <= 1'b0;
                        div_zero  <= (clear == '0);
                        if (clear == '0) begin
                            color     <= '0;
                            calc_done <= 1'b1;
                        end
                    end
                end
                DIV: begin
                    dividend  <= dividend << 1;
                    remainder <= rem_next;
                    quotient  <= quot_next;
                    bit_cnt   <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        calc_done <= 1'b1;
                        if (quot_next > NUM_W'(SCALE)) begin
                            color     <= 8'(SCALE);
                            saturated <= 1'b1;
                        end else begin
                            color     <= quot_next[7:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
